// File: rtl/load_store_queue.sv
// rtl/load_store_queue.sv - in-order load/store queue issuing one data-memory transaction at a time
module load_store_queue #(
  parameter int P_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        clk_en_i,
  input  logic        resetb_i,
  input  logic        ex_lq_wr_i,
  input  logic        ex_sq_wr_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic [4:0]  ex_regd_addr_i,
  input  logic [31:0] ex_regs2_data_i,
  input  logic [31:0] ex_addr_i,
  output logic        ex_full_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_regd_wr_o,
  output logic [4:0]  wb_regd_addr_o,
  output logic [31:0] wb_regd_data_o,
  output logic        lsq_fault_o,
  output logic [31:0] lsq_fault_addr_o
);
  localparam int AW = $clog2(P_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(P_DEPTH);

  typedef struct packed {
    logic        st;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] addr;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R} state_t;

  entry_t        q_mem [P_DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  state_t        state_q, state_d;
  logic          empty, enq, pop, fault_set, wb_set, head_legal;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c, load_c;
  logic [7:0]    byte_c;
  logic [15:0]   half_c;
  logic          fault_q, wb_wr_q;
  logic [31:0]   fault_addr_q, wb_data_q;
  logic [4:0]    wb_addr_q;

  assign head      = q_mem[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign ex_full_o = (count_q == DEPTH_C);
  assign enq       = (ex_lq_wr_i | ex_sq_wr_i) & ~ex_full_o;

  always_ff @(posedge clk_i) begin
    if (clk_en_i && enq) begin
      // Both strobes set is treated as a load.
      q_mem[wr_ptr_q] <= '{st: ex_sq_wr_i & ~ex_lq_wr_i, f3: ex_funct3_i, rd: ex_regd_addr_i,
                           data: ex_regs2_data_i, addr: ex_addr_i};
    end
  end

  always_comb begin
    head_legal = 1'b1;
    case (head.f3)
      3'b000, 3'b100: head_legal = 1'b1;
      3'b001, 3'b101: head_legal = ~head.addr[0];
      3'b010:         head_legal = (head.addr[1:0] == 2'b00);
      default:        head_legal = 1'b0;
    endcase
    if (head.st && head.f3[2]) head_legal = 1'b0;
  end

  always_comb begin
    be_c    = 4'hF;
    wdata_c = head.data;
    case (head.f3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << head.addr[1:0];
        wdata_c = {4{head.data[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << {head.addr[1], 1'b0};
        wdata_c = {2{head.data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (head.addr[1:0])
      2'b00:   byte_c = dmem_rdata_i[7:0];
      2'b01:   byte_c = dmem_rdata_i[15:8];
      2'b10:   byte_c = dmem_rdata_i[23:16];
      default: byte_c = dmem_rdata_i[31:24];
    endcase
    half_c = head.addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (head.f3)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b100:  load_c = {24'd0, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b101:  load_c = {16'd0, half_c};
      default: load_c = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    fault_set = 1'b0;
    wb_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          if (head_legal) begin
            state_d = S_REQ;
          end else begin
            pop       = 1'b1;
            fault_set = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (dmem_gnt_i) begin
          if (head.st) begin
            pop     = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_R;
          end
        end
      end
      S_WAIT_R: begin
        if (dmem_rvalid_i) begin
          pop     = 1'b1;
          wb_set  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      wb_wr_q      <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
    end else if (clk_en_i) begin
      state_q      <= state_d;
      if (enq) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q      <= count_q + CW'(enq) - CW'(pop);
      fault_q      <= fault_set;
      fault_addr_q <= fault_set ? head.addr : '0;
      // Loads to x0 still use the bus but never write back.
      wb_wr_q      <= wb_set && (head.rd != 5'd0);
      wb_addr_q    <= (wb_set && (head.rd != 5'd0)) ? head.rd : '0;
      wb_data_q    <= (wb_set && (head.rd != 5'd0)) ? load_c : '0;
    end
  end

  assign dmem_req_o       = (state_q == S_REQ);
  assign dmem_we_o        = dmem_req_o & head.st;
  assign dmem_addr_o      = dmem_req_o ? {head.addr[31:2], 2'b00} : '0;
  assign dmem_be_o        = dmem_req_o ? be_c : '0;
  assign dmem_wdata_o     = dmem_we_o ? wdata_c : '0;
  assign wb_regd_wr_o     = wb_wr_q;
  assign wb_regd_addr_o   = wb_addr_q;
  assign wb_regd_data_o   = wb_data_q;
  assign lsq_fault_o      = fault_q;
  assign lsq_fault_addr_o = fault_addr_q;

  always_ff @(posedge clk_i) begin
    if (resetb_i && clk_en_i) begin
      assert (!((ex_lq_wr_i || ex_sq_wr_i) && ex_full_o))
        else $warning("load_store_queue: enqueue while full dropped");
      assert (!(ex_lq_wr_i && ex_sq_wr_i))
        else $warning("load_store_queue: load and store enqueued together, kept as load");
    end
  end
endmodule

// File: tb/tb_load_store_queue.sv
// tb/tb_load_store_queue.sv - directed and randomized check of load_store_queue against a queue model
module tb_load_store_queue;
  logic        clk_i = 1'b0;
  logic        clk_en_i, resetb_i;
  logic        ex_lq_wr_i, ex_sq_wr_i;
  logic [2:0]  ex_funct3_i;
  logic [4:0]  ex_regd_addr_i;
  logic [31:0] ex_regs2_data_i, ex_addr_i;
  logic        ex_full_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic        wb_regd_wr_o;
  logic [4:0]  wb_regd_addr_o;
  logic [31:0] wb_regd_data_o;
  logic        lsq_fault_o;
  logic [31:0] lsq_fault_addr_o;

  load_store_queue #(.P_DEPTH(4)) dut (
    .clk_i(clk_i), .clk_en_i(clk_en_i), .resetb_i(resetb_i),
    .ex_lq_wr_i(ex_lq_wr_i), .ex_sq_wr_i(ex_sq_wr_i), .ex_funct3_i(ex_funct3_i),
    .ex_regd_addr_i(ex_regd_addr_i), .ex_regs2_data_i(ex_regs2_data_i), .ex_addr_i(ex_addr_i),
    .ex_full_o(ex_full_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_regd_wr_o(wb_regd_wr_o), .wb_regd_addr_o(wb_regd_addr_o), .wb_regd_data_o(wb_regd_data_o),
    .lsq_fault_o(lsq_fault_o), .lsq_fault_addr_o(lsq_fault_addr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit        st;
    bit [2:0]  f3;
    bit [4:0]  rd;
    bit [31:0] data;
    bit [31:0] addr;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] fault_seen[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_wb;

  always @(posedge clk_i) begin
    #2;
    if (resetb_i && lsq_fault_o) fault_seen.push_back(lsq_fault_addr_o);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input bit [2:0] f3);
    case (f3 % 4)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit legal(input ent_t e);
    if (e.f3 == 3 || e.f3 > 5) return 0;
    if (e.st && e.f3 > 2) return 0;
    return (e.addr % nbytes(e.f3)) == 0;
  endfunction

  function automatic logic [31:0] exp_be(input ent_t e);
    int n = nbytes(e.f3);
    return 32'(((1 << n) - 1) << (e.addr % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input ent_t e);
    int n = nbytes(e.f3);
    if (n == 1) return (e.data & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (e.data & 32'hFFFF) * 32'h0001_0001;
    return e.data;
  endfunction

  function automatic logic [31:0] exp_load(input ent_t e, input logic [31:0] rdata);
    int     n = nbytes(e.f3);
    longint v = 0;
    v[31:0] = rdata;
    v = (v >> (8 * (e.addr % 4))) & ((longint'(1) << (8 * n)) - 1);
    if (e.f3 < 4 && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic enq(input bit st, input bit [2:0] f3, input bit [4:0] rd,
                     input bit [31:0] data, input bit [31:0] addr, input bit chk_full);
    ent_t e;
    e.st = st; e.f3 = f3; e.rd = rd; e.data = data; e.addr = addr;
    if (chk_full) chk("full_flag", 32'(ex_full_o), 32'(exp_q.size() == 4));
    ex_lq_wr_i = !st; ex_sq_wr_i = st; ex_funct3_i = f3;
    ex_regd_addr_i = rd; ex_regs2_data_i = data; ex_addr_i = addr;
    if (exp_q.size() < 4) exp_q.push_back(e);
    @(negedge clk_i);
    ex_lq_wr_i = 1'b0; ex_sq_wr_i = 1'b0;
  endtask

  task automatic serve(input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
    ent_t e;
    int   n = 0;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    if (!legal(e)) begin
      while (fault_seen.size() == 0 && n < 20) begin
        chk("no_req_on_illegal", 32'(dmem_req_o), 32'd0);
        @(negedge clk_i);
        n++;
      end
      chk("fault_seen", 32'(fault_seen.size() > 0), 32'd1);
      if (fault_seen.size() > 0) chk("fault_addr", fault_seen.pop_front(), e.addr);
      return;
    end
    while (!dmem_req_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("req_seen", 32'(dmem_req_o), 32'd1);
    chk("we", 32'(dmem_we_o), 32'(e.st));
    chk("addr", dmem_addr_o, e.addr & ~32'h3);
    chk("be", 32'(dmem_be_o), exp_be(e));
    if (e.st) chk("wdata", dmem_wdata_o, exp_wdata(e));
    for (int i = 0; i < gnt_dly; i++) begin
      @(negedge clk_i);
      chk("req_hold", 32'(dmem_req_o), 32'd1);
    end
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    chk("req_drop", 32'(dmem_req_o), 32'd0);
    if (!e.st) begin
      for (int i = 0; i < rv_dly; i++) begin
        @(negedge clk_i);
        chk("no_early_wb", 32'(wb_regd_wr_o), 32'd0);
      end
      dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
      @(negedge clk_i);
      dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
      chk("wb_wr", 32'(wb_regd_wr_o), 32'(e.rd != 0));
      if (e.rd != 0) begin
        chk("wb_addr", 32'(wb_regd_addr_o), 32'(e.rd));
        chk("wb_data", wb_regd_data_o, exp_load(e, rdata));
      end
      last_wb = wb_regd_data_o;
      @(negedge clk_i);
      chk("wb_pulse", 32'(wb_regd_wr_o), 32'd0);
    end
  endtask

  initial begin
    int n;
    clk_en_i = 1'b1; resetb_i = 1'b0;
    ex_lq_wr_i = 1'b0; ex_sq_wr_i = 1'b0; ex_funct3_i = '0; ex_regd_addr_i = '0;
    ex_regs2_data_i = '0; ex_addr_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_full", 32'(ex_full_o), 32'd0);
    chk("rst_wb", 32'(wb_regd_wr_o), 32'd0);
    chk("rst_fault", 32'(lsq_fault_o), 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    resetb_i = 1'b1;
    @(negedge clk_i);

    // SW with grant after two extra cycles: request visible for three cycles.
    enq(1, 3'b010, 0, 32'h1234_5678, 32'h100, 1);
    chk("lat_edge_e", 32'(dmem_req_o), 32'd0);
    @(negedge clk_i);
    chk("lat_edge_e1", 32'(dmem_req_o), 32'd1);
    serve(2, 0, 0);
    repeat (3) @(negedge clk_i);
    chk("idle_after_sw", 32'(dmem_req_o), 32'd0);
    chk("empty_after_sw", 32'(ex_full_o), 32'd0);

    enq(0, 3'b000, 5, 0, 32'h103, 1);
    serve(0, 1, 32'h80FF_FF00);
    chk("lb_const", last_wb, 32'hFFFF_FF80);
    enq(0, 3'b100, 5, 0, 32'h103, 1);
    serve(1, 0, 32'h80FF_FF00);
    chk("lbu_const", last_wb, 32'h0000_0080);
    enq(0, 3'b101, 6, 0, 32'h102, 1);
    serve(0, 2, 32'h80FF_FF00);
    chk("lhu_const", last_wb, 32'h0000_80FF);
    enq(0, 3'b010, 0, 0, 32'h40, 1);
    serve(1, 0, 32'hDEAD_BEEF);

    // Fill to full with the bus stalled; the fifth enqueue is dropped.
    enq(1, 3'b000, 0, 32'h11, 32'h201, 1);
    enq(0, 3'b001, 9, 0, 32'h206, 1);
    enq(1, 3'b001, 0, 32'hBEEF, 32'h20A, 1);
    enq(0, 3'b010, 10, 0, 32'h20C, 1);
    enq(1, 3'b010, 0, 32'h5555_AAAA, 32'h210, 1);
    chk("full_hold", 32'(ex_full_o), 32'd1);
    repeat (4) serve(0, 0, $urandom);
    chk("drained", 32'(ex_full_o), 32'd0);

    // Misaligned LW faults and the following store still issues.
    enq(0, 3'b010, 3, 0, 32'h101, 1);
    enq(1, 3'b010, 0, 32'hCAFE_BABE, 32'h200, 1);
    serve(0, 0, 0);
    serve(0, 0, 0);

    // Reset while waiting for load data.
    enq(0, 3'b010, 7, 0, 32'h300, 1);
    n = 0;
    while (!dmem_req_o && n < 20) begin @(negedge clk_i); n++; end
    chk("wr_req_seen", 32'(dmem_req_o), 32'd1);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    resetb_i = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dmem_req_o), 32'd0);
    chk("mid_rst_wb", 32'(wb_regd_wr_o), 32'd0);
    @(negedge clk_i);
    resetb_i = 1'b1;
    exp_q.delete();
    fault_seen.delete();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555_1234;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    chk("late_rvalid_wb", 32'(wb_regd_wr_o), 32'd0);
    chk("late_rvalid_data", wb_regd_data_o, 32'd0);
    repeat (2) @(negedge clk_i);
    chk("rst_empty_req", 32'(dmem_req_o), 32'd0);

    // Clock enable low freezes REQ even with grant high.
    enq(1, 3'b000, 0, 32'hA5, 32'h7, 1);
    n = 0;
    while (!dmem_req_o && n < 20) begin @(negedge clk_i); n++; end
    chk("ce_req_seen", 32'(dmem_req_o), 32'd1);
    chk("ce_be", 32'(dmem_be_o), 32'h8);
    clk_en_i = 1'b0; dmem_gnt_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("ce_frozen_req", 32'(dmem_req_o), 32'd1);
    end
    clk_en_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    chk("ce_popped", 32'(dmem_req_o), 32'd0);
    void'(exp_q.pop_front());
    @(negedge clk_i);
    chk("ce_no_reissue", 32'(dmem_req_o), 32'd0);

    // Random bursts of loads/stores, mostly legal, drained with random bus delays.
    repeat (25) begin
      int k = $urandom_range(1, 4);
      for (int i = 0; i < k; i++) begin
        bit        st = 1'($urandom % 2);
        bit [2:0]  f3 = 3'($urandom_range(0, 7));
        bit [31:0] a  = $urandom;
        if ($urandom % 4 != 0) begin
          if (st) f3 = 3'($urandom_range(0, 2));
          else begin
            case ($urandom_range(0, 4))
              0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
            endcase
          end
          a = a & ~32'(nbytes(f3) - 1);
        end
        enq(st, f3, 5'($urandom), $urandom, a, 0);
      end
      while (exp_q.size() > 0) serve($urandom_range(0, 2), $urandom_range(0, 2), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
